sw_input_conditioner: RTL and testbench

Front-end stage for the switch-driven FIFO: it synchronizes raw board switches, debounces the push and pop controls, and turns each debounced press into a single-cycle write or read request into the FIFO. Its outputs connect directly to the FIFO write and read ports. It suppresses requests the FIFO cannot accept and flags each suppressed request.

---
 rtl/sw_cond_pkg.sv | 22 ++
 rtl/sw_debounce.sv | 168 ++++++++++++++++
 rtl/sw_input_conditioner.sv | 129 ++++++++++++
 tb/tb_sw_input_conditioner.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sw_cond_pkg.sv
// Shared types and default constants for the switch input conditioner.
package sw_cond_pkg;

  localparam int SW_DATA_W          = 4;
  localparam int SW_DEBOUNCE_CYCLES = 16;
  localparam int SW_REPEAT_CYCLES   = 64;

  // Top-level FSM: INIT tracks switch levels silently, RUN issues requests.
  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } top_state_t;

  // Per-channel debounce FSM.
  typedef enum logic [1:0] {
    LOW      = 2'd0,
    CHK_HIGH = 2'd1,
    HIGH     = 2'd2,
    CHK_LOW  = 2'd3
  } db_state_t;

endpackage

// File: rtl/sw_debounce.sv
// One switch channel: 2-flop synchronizer, debounce FSM with saturating
// stability counter, and a registered commit strobe on each stable rising
// edge. Optional auto-repeat is compiled in with SW_AUTOREPEAT_EN.
module sw_debounce
  import sw_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES,
  parameter int REPEAT_CYCLES   = SW_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  input  logic i_init,
  output logic o_stable,
  output logic o_commit
);

  localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  generate
    if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_bad_cfg
      $error("sw_debounce: DEBOUNCE_CYCLES must be >= 2 and REPEAT_CYCLES >= 1");
    end
  endgenerate

  logic             r_sync1;
  logic             r_sync2;
  db_state_t        r_state;
  db_state_t        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             r_stable;
  logic             w_stable_nxt;
  logic             r_commit;
  logic             w_rise;
  logic             w_rpt_fire;

  // Two-flop synchronizer for the raw switch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce state, counter, stable level and commit strobe registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= LOW;
      r_cnt    <= '0;
      r_stable <= 1'b0;
      r_commit <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_stable <= w_stable_nxt;
      r_commit <= w_rise | w_rpt_fire;
    end
  end

  // Next-state logic: the first differing sample (in the stable state)
  // counts as 1, so the level flips on the DEBOUNCE_CYCLES-th sample.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_stable_nxt = r_stable;
    w_cnt_inc    = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + CNT_ONE;
    if (i_init) begin
      // Silent tracking: adopt the synchronized level with no edge.
      w_stable_nxt = r_sync2;
      w_state_nxt  = r_sync2 ? HIGH : LOW;
      w_cnt_nxt    = '0;
    end else begin
      unique case (r_state)
        LOW: begin
          if (r_sync2) begin
            w_state_nxt = CHK_HIGH;
            w_cnt_nxt   = CNT_ONE;
          end
        end
        CHK_HIGH: begin
          if (!r_sync2) begin
            w_state_nxt = LOW;
            w_cnt_nxt   = '0;
          end else if (w_cnt_inc == CNT_MAX) begin
            w_state_nxt  = HIGH;
            w_stable_nxt = 1'b1;
            w_cnt_nxt    = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        HIGH: begin
          if (!r_sync2) begin
            w_state_nxt = CHK_LOW;
            w_cnt_nxt   = CNT_ONE;
          end
        end
        CHK_LOW: begin
          if (r_sync2) begin
            w_state_nxt = HIGH;
            w_cnt_nxt   = '0;
          end else if (w_cnt_inc == CNT_MAX) begin
            w_state_nxt  = LOW;
            w_stable_nxt = 1'b0;
            w_cnt_nxt    = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        default: begin
          w_state_nxt = LOW;
          w_cnt_nxt   = '0;
        end
      endcase
    end
    w_rise = !i_init && !r_stable && w_stable_nxt;
  end

`ifdef SW_AUTOREPEAT_EN
  localparam int               RPT_W    = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);
  localparam logic [RPT_W-1:0] RPT_ONE  = RPT_W'(1);

  logic [RPT_W-1:0] r_rpt_cnt;
  logic [RPT_W-1:0] w_rpt_nxt;

  // Repeat period counter; runs only while the level stays high in RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rpt_cnt <= '0;
    end else begin
      r_rpt_cnt <= w_rpt_nxt;
    end
  end

  // Fire a repeat commit every REPEAT_CYCLES cycles after the press.
  always_comb begin
    w_rpt_fire = 1'b0;
    w_rpt_nxt  = '0;
    if (!i_init && r_stable && w_stable_nxt) begin
      if (r_rpt_cnt >= RPT_LAST) begin
        w_rpt_fire = 1'b1;
      end else begin
        w_rpt_nxt = r_rpt_cnt + RPT_ONE;
      end
    end
  end
`else
  // Without auto-repeat only the stable rising edge commits.
  always_comb begin
    w_rpt_fire = 1'b0;
  end
`endif

  // Outputs come straight from registers.
  always_comb begin
    o_stable = r_stable;
    o_commit = r_commit;
  end

endmodule

// File: rtl/sw_input_conditioner.sv
// Switch front end for the switch-driven FIFO: synchronizes data, debounces
// push/pop, and turns each press into a one-cycle write/read request gated
// by full/empty, flagging suppressed requests. Optional macro:
// SW_AUTOREPEAT_EN enables auto-repeat while a switch is held.
module sw_input_conditioner
  import sw_cond_pkg::*;
#(
  parameter int DATA_W          = SW_DATA_W,
  parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES,
  parameter int REPEAT_CYCLES   = SW_REPEAT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sw_data,
  input  logic              sw_push,
  input  logic              sw_pop,
  input  logic              full,
  input  logic              empty,
  output logic              wr_en,
  output logic [DATA_W-1:0] wr_data,
  output logic              rd_en,
  output logic              drop_wr,
  output logic              drop_rd
);

  // INIT lasts 2+DEBOUNCE_CYCLES cycles: long enough for the synchronizer
  // to fill so held switches are adopted as the starting level.
  localparam int                INIT_W    = $clog2(DEBOUNCE_CYCLES + 3);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(DEBOUNCE_CYCLES + 1);
  localparam logic [INIT_W-1:0] INIT_ONE  = INIT_W'(1);

  top_state_t        r_state;
  top_state_t        w_state_nxt;
  logic [INIT_W-1:0] r_init_cnt;
  logic              w_init;
  logic              w_run;
  logic [DATA_W-1:0] r_data_s1;
  logic [DATA_W-1:0] r_data_s2;
  logic              w_push_stable;
  logic              w_push_commit;
  logic              w_pop_stable;
  logic              w_pop_commit;
  logic              w_push_req;
  logic              w_pop_req;

  // Data switches are synchronized only, never debounced.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data_s1 <= '0;
      r_data_s2 <= '0;
    end else begin
      r_data_s1 <= sw_data;
      r_data_s2 <= r_data_s1;
    end
  end

  sw_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_CYCLES   (REPEAT_CYCLES)
  ) u_push_db (
    .clk      (clk),
    .rst      (rst),
    .i_raw    (sw_push),
    .i_init   (w_init),
    .o_stable (w_push_stable),
    .o_commit (w_push_commit)
  );

  sw_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_CYCLES   (REPEAT_CYCLES)
  ) u_pop_db (
    .clk      (clk),
    .rst      (rst),
    .i_raw    (sw_pop),
    .i_init   (w_init),
    .o_stable (w_pop_stable),
    .o_commit (w_pop_commit)
  );

  // Top FSM state register and saturating INIT counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= INIT;
      r_init_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == INIT && r_init_cnt != INIT_LAST) begin
        r_init_cnt <= r_init_cnt + INIT_ONE;
      end
    end
  end

  // Next state: leave INIT once the counter expires, then stay in RUN.
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == INIT && r_init_cnt == INIT_LAST) begin
      w_state_nxt = RUN;
    end
  end

  // FSM outputs: INIT silences the channels; requests only in RUN.
  always_comb begin
    w_init     = (r_state == INIT);
    w_run      = (r_state == RUN);
    w_push_req = w_run && w_push_commit && w_push_stable;
    w_pop_req  = w_run && w_pop_commit && w_pop_stable;
  end

  // Registered requests; full/empty are looked at only in the commit cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_data <= '0;
      rd_en   <= 1'b0;
      drop_wr <= 1'b0;
      drop_rd <= 1'b0;
    end else begin
      wr_en   <= w_push_req && !full;
      drop_wr <= w_push_req && full;
      rd_en   <= w_pop_req && !empty;
      drop_rd <= w_pop_req && empty;
      if (w_push_req && !full) begin
        wr_data <= r_data_s2;
      end
    end
  end

endmodule

// File: tb/tb_sw_input_conditioner.sv
// Directed bench for sw_input_conditioner with DEBOUNCE_CYCLES=16.
module tb_sw_input_conditioner;

  localparam int DW  = 4;
  localparam int DB  = 16;
  localparam int RPT = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] sw_data = '0;
  logic          sw_push = 1'b0;
  logic          sw_pop = 1'b0;
  logic          full = 1'b0;
  logic          empty = 1'b0;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic          drop_wr;
  logic          drop_rd;

  int n_pass  = 0;
  int n_total = 0;

  sw_input_conditioner #(
    .DATA_W          (DW),
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_CYCLES   (RPT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .sw_data (sw_data),
    .sw_push (sw_push),
    .sw_pop  (sw_pop),
    .full    (full),
    .empty   (empty),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .drop_wr (drop_wr),
    .drop_rd (drop_rd)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs n cycles and tallies output activity; cycle i is the i-th edge.
  task automatic watch(input int n, output int wr_c, output int rd_c,
                       output int dw_c, output int dr_c, output int wr_first,
                       output int wr_last, output int both_c);
    wr_c = 0; rd_c = 0; dw_c = 0; dr_c = 0; both_c = 0;
    wr_first = -1; wr_last = -1;
    for (int i = 1; i <= n; i++) begin
      step();
      if (wr_en) begin
        wr_c++;
        if (wr_first < 0) wr_first = i;
        wr_last = i;
      end
      if (rd_en) rd_c++;
      if (drop_wr) dw_c++;
      if (drop_rd) dr_c++;
      if (wr_en && rd_en) both_c++;
    end
  endtask

  task automatic test_reset();
    int wc, rc, dwc, drc, f, l, b;
    #2 rst = 1'b1;
    #1;
    n_total++;
    if ({wr_en, rd_en, drop_wr, drop_rd, wr_data} !== 8'h00)
      $display("FAIL reset_outputs got=%h want=00", {wr_en, rd_en, drop_wr, drop_rd, wr_data});
    else n_pass++;
    step(); step();
    rst = 1'b0;
    watch(25, wc, rc, dwc, drc, f, l, b);
    n_total++;
    if (wc + rc + dwc + drc !== 0)
      $display("FAIL init_quiet got=%0d pulses want=0", wc + rc + dwc + drc);
    else n_pass++;
  endtask

  task automatic test_single_push();
    int wc, rc, dwc, drc, f, l, b;
    sw_data = 4'h5;
    sw_push = 1'b1;
    watch(40, wc, rc, dwc, drc, f, l, b);
    n_total++;
    if (wc !== 1) $display("FAIL push_count got=%0d want=1", wc); else n_pass++;
    n_total++;
    if (f !== 1 + 2 + DB) $display("FAIL push_latency got=%0d want=%0d", f, 1 + 2 + DB); else n_pass++;
    n_total++;
    if (wr_data !== 4'h5) $display("FAIL push_data got=%h want=5", wr_data); else n_pass++;
    n_total++;
    if (dwc !== 0) $display("FAIL push_nodrop got=%0d want=0", dwc); else n_pass++;
    sw_push = 1'b0;
    watch(30, wc, rc, dwc, drc, f, l, b);
    n_total++;
    if (wc + dwc !== 0) $display("FAIL release_quiet got=%0d want=0", wc + dwc); else n_pass++;
  endtask

  task automatic test_bounce();
    int wc, rc, dwc, drc, f, l, b;
    int tw, td;
    tw = 0; td = 0;
    sw_data = 4'h3;
    for (int i = 0; i < 20; i++) begin
      sw_push = ~sw_push;
      watch(3, wc, rc, dwc, drc, f, l, b);
      tw += wc; td += dwc;
    end
    sw_push = 1'b0;
    watch(30, wc, rc, dwc, drc, f, l, b);
    tw += wc; td += dwc;
    n_total++;
    if (tw !== 0) $display("FAIL bounce_wr got=%0d want=0", tw); else n_pass++;
    n_total++;
    if (td !== 0) $display("FAIL bounce_drop got=%0d want=0", td); else n_pass++;
    n_total++;
    if (wr_data !== 4'h5) $display("FAIL bounce_data got=%h want=5", wr_data); else n_pass++;
  endtask

  task automatic test_full_drop();
    int wc, rc, dwc, drc, f, l, b;
    full = 1'b1;
    sw_data = 4'hA;
    sw_push = 1'b1;
    watch(25, wc, rc, dwc, drc, f, l, b);
    sw_push = 1'b0;
    n_total++;
    if (dwc !== 1) $display("FAIL full_drop_wr got=%0d want=1", dwc); else n_pass++;
    n_total++;
    if (wc !== 0) $display("FAIL full_wr_en got=%0d want=0", wc); else n_pass++;
    n_total++;
    if (wr_data !== 4'h5) $display("FAIL full_data_held got=%h want=5", wr_data); else n_pass++;
    watch(25, wc, rc, dwc, drc, f, l, b);
    full = 1'b0;
  endtask

  task automatic test_empty_drop();
    int wc, rc, dwc, drc, f, l, b;
    empty = 1'b1;
    sw_pop = 1'b1;
    watch(25, wc, rc, dwc, drc, f, l, b);
    sw_pop = 1'b0;
    n_total++;
    if (drc !== 1) $display("FAIL empty_drop_rd got=%0d want=1", drc); else n_pass++;
    n_total++;
    if (rc !== 0) $display("FAIL empty_rd_en got=%0d want=0", rc); else n_pass++;
    n_total++;
    if (wc + dwc !== 0) $display("FAIL empty_no_push got=%0d want=0", wc + dwc); else n_pass++;
    watch(25, wc, rc, dwc, drc, f, l, b);
    empty = 1'b0;
  endtask

  task automatic test_back_to_back();
    int wc, rc, dwc, drc, f, l, b;
    sw_data = 4'hC;
    sw_push = 1'b1;
    sw_pop  = 1'b1;
    watch(30, wc, rc, dwc, drc, f, l, b);
    sw_push = 1'b0;
    sw_pop  = 1'b0;
    n_total++;
    if (b !== 1) $display("FAIL both_same_cycle got=%0d want=1", b); else n_pass++;
    n_total++;
    if (rc !== 1) $display("FAIL both_rd_count got=%0d want=1", rc); else n_pass++;
    n_total++;
    if (wr_data !== 4'hC) $display("FAIL both_data got=%h want=c", wr_data); else n_pass++;
    watch(30, wc, rc, dwc, drc, f, l, b);
  endtask

  task automatic test_reset_held();
    int wc, rc, dwc, drc, f, l, b;
    sw_data = 4'h7;
    sw_push = 1'b1;
    rst = 1'b1;
    step(); step(); step();
    rst = 1'b0;
    watch(40, wc, rc, dwc, drc, f, l, b);
    n_total++;
    if (wc + dwc !== 0) $display("FAIL held_thru_reset got=%0d want=0", wc + dwc); else n_pass++;
    sw_push = 1'b0;
    watch(30, wc, rc, dwc, drc, f, l, b);
    sw_push = 1'b1;
    watch(40, wc, rc, dwc, drc, f, l, b);
    n_total++;
    if (wc !== 1) $display("FAIL repress_count got=%0d want=1", wc); else n_pass++;
    n_total++;
    if (f !== 1 + 2 + DB) $display("FAIL repress_latency got=%0d want=%0d", f, 1 + 2 + DB); else n_pass++;
    sw_push = 1'b0;
    watch(30, wc, rc, dwc, drc, f, l, b);
  endtask

  task automatic test_reset_mid_chk();
    int wc, rc, dwc, drc, f, l, b;
    int nz;
    nz = 0;
    sw_data = 4'hE;
    sw_push = 1'b1;
    watch(10, wc, rc, dwc, drc, f, l, b);
    nz += wc + dwc;
    rst = 1'b1;
    #1;
    n_total++;
    if (wr_data !== 4'h0) $display("FAIL midreset_data got=%h want=0", wr_data); else n_pass++;
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if ({wr_en, rd_en, drop_wr, drop_rd, wr_data} !== 8'h00) nz++;
    end
    n_total++;
    if (nz !== 0) $display("FAIL midreset_quiet got=%0d want=0", nz); else n_pass++;
    sw_push = 1'b0;
    watch(30, wc, rc, dwc, drc, f, l, b);
  endtask

  task automatic test_autorepeat();
    int wc, rc, dwc, drc, f, l, b;
    int exp_c, exp_l;
`ifdef SW_AUTOREPEAT_EN
    exp_c = 5;
    exp_l = 1 + 2 + DB + 4 * RPT;
`else
    exp_c = 1;
    exp_l = 1 + 2 + DB;
`endif
    sw_data = 4'h9;
    sw_push = 1'b1;
    watch(2 + DB + 300, wc, rc, dwc, drc, f, l, b);
    sw_push = 1'b0;
    n_total++;
    if (wc !== exp_c) $display("FAIL repeat_count got=%0d want=%0d", wc, exp_c); else n_pass++;
    n_total++;
    if (l !== exp_l) $display("FAIL repeat_last got=%0d want=%0d", l, exp_l); else n_pass++;
    n_total++;
    if (wr_data !== 4'h9) $display("FAIL repeat_data got=%h want=9", wr_data); else n_pass++;
    watch(30, wc, rc, dwc, drc, f, l, b);
    n_total++;
    if (wc !== 0) $display("FAIL repeat_release got=%0d want=0", wc); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_bounce();
    test_full_drop();
    test_empty_drop();
    test_back_to_back();
    test_reset_held();
    test_reset_mid_chk();
    test_autorepeat();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
